// File: rtl/usr_multi_shift.sv
// WIDTH-bit universal shift/rotate register driven by one command at a time over valid/ready.
// Latency: LOAD/CLEAR/NOP/N=0 complete at the accept edge; shift/rotate take N edges, one bit per edge.
// Backpressure: cmd_ready is low while a multi-step command runs; cmd_valid is ignored until back in IDLE.
module usr_multi_shift #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [CW-1:0]    cmd_count,
    input  logic [WIDTH-1:0] pi,
    input  logic             sl_r,
    input  logic             sl_l,
    output logic [WIDTH-1:0] z,
    output logic             so,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] M_NOP   = 3'b000;
    localparam logic [2:0] M_SHR   = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_LOAD  = 3'b011;
    localparam logic [2:0] M_ROR   = 3'b100;
    localparam logic [2:0] M_ROL   = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    localparam logic [CW-1:0] ONE = CW'(1);

    state_t          state;
    logic [2:0]      mode_q;
    logic [CW-1:0]   remaining;
    logic [2:0]      step_mode;
    logic [WIDTH-1:0] step_z;
    logic            step_so;
    logic            cmd_is_step;
    logic            accept;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);
    assign accept    = cmd_valid && cmd_ready;

    // In IDLE the first step uses the incoming mode; in RUN the latched one.
    assign step_mode = (state == RUN) ? mode_q : cmd_mode;

    assign cmd_is_step = (cmd_mode == M_SHR) || (cmd_mode == M_SHL) ||
                         (cmd_mode == M_ROR) || (cmd_mode == M_ROL) ||
                         (cmd_mode == M_ASR);

    // One single-bit step of the selected shift/rotate; serial inputs sampled live.
    always_comb begin
        step_z  = z;
        step_so = so;
        case (step_mode)
            M_SHR: begin
                step_z  = {sl_r, z[WIDTH-1:1]};
                step_so = z[0];
            end
            M_SHL: begin
                step_z  = {z[WIDTH-2:0], sl_l};
                step_so = z[WIDTH-1];
            end
            M_ROR: begin
                step_z  = {z[0], z[WIDTH-1:1]};
                step_so = z[0];
            end
            M_ROL: begin
                step_z  = {z[WIDTH-2:0], z[WIDTH-1]};
                step_so = z[WIDTH-1];
            end
            M_ASR: begin
                step_z  = {z[WIDTH-1], z[WIDTH-1:1]};
                step_so = z[0];
            end
            default: begin
                step_z  = z;
                step_so = so;
            end
        endcase
    end

    // Command FSM: accept in IDLE, step once per edge in RUN, pulse done after the final update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mode_q    <= M_NOP;
            remaining <= '0;
            z         <= '0;
            so        <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_mode == M_LOAD) begin
                            z    <= pi;
                            done <= 1'b1;
                        end else if (cmd_mode == M_CLEAR) begin
                            z    <= '0;
                            so   <= 1'b0;
                            done <= 1'b1;
                        end else if (cmd_is_step && (cmd_count != '0)) begin
                            z  <= step_z;
                            so <= step_so;
                            if (cmd_count == ONE) begin
                                done <= 1'b1;
                            end else begin
                                state     <= RUN;
                                mode_q    <= cmd_mode;
                                remaining <= cmd_count - ONE;
                            end
                        end else begin
                            // NOP or zero-length shift: nothing moves, but the command still completes.
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    z         <= step_z;
                    so        <= step_so;
                    remaining <= remaining - ONE;
                    if (remaining == ONE) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usr_multi_shift.sv
module tb_usr_multi_shift;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    localparam logic [2:0] M_NOP   = 3'b000;
    localparam logic [2:0] M_SHR   = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_LOAD  = 3'b011;
    localparam logic [2:0] M_ROR   = 3'b100;
    localparam logic [2:0] M_ROL   = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_mode;
    logic [CW-1:0]    cmd_count;
    logic [WIDTH-1:0] pi;
    logic             sl_r;
    logic             sl_l;
    logic [WIDTH-1:0] z;
    logic             so;
    logic             busy;
    logic             done;

    usr_multi_shift #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_count (cmd_count),
        .pi        (pi),
        .sl_r      (sl_r),
        .sl_l      (sl_l),
        .z         (z),
        .so        (so),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       mode;
        logic [CW-1:0]    count;
        logic [WIDTH-1:0] pi;
        logic             sl_r;
        logic             sl_l;
        logic [WIDTH-1:0] exp_z;
        logic             exp_so;
        int               exp_busy;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] z;
        logic             so;
        int               busy_cycles;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[17];

    int n_cmp  = 0;
    int n_fail = 0;
    int busy_cnt = 0;
    int rdy_lo_cnt = 0;
    bit mon_on = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic stop_now(input string why);
        n_fail++;
        $display("FAIL %s: bound expired at %0t", why, $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "bench aborted");
    endtask

    // Drive a command from a negedge and return at the negedge after it is accepted.
    task automatic start_cmd(input logic [2:0] m, input logic [CW-1:0] n, input logic [WIDTH-1:0] p,
                             input logic sr, input logic sl, input bit push,
                             input logic [WIDTH-1:0] ez, input logic eso, input int eb);
        exp_t e;
        bit acc;
        e.z = ez;
        e.so = eso;
        e.busy_cycles = eb;
        if (push) sb.push_back(e);
        cmd_mode  = m;
        cmd_count = n;
        pi        = p;
        sl_r      = sr;
        sl_l      = sl;
        cmd_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 200; k++) begin
            if (cmd_ready) begin
                @(posedge clk);
                acc = 1;
                break;
            end
            @(negedge clk);
        end
        if (!acc) stop_now("accept_timeout");
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) stop_now("idle_timeout");
    endtask

    // Scoreboard monitor: every done pops one expectation; busy/ready lengths checked per command.
    always @(negedge clk) begin
        if (mon_on) begin
            if (!rst) begin
                busy_cnt   = 0;
                rdy_lo_cnt = 0;
            end else begin
                chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~cmd_ready});
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("spurious_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("z", {24'd0, z}, {24'd0, e.z});
                        chk("so", {31'd0, so}, {31'd0, e.so});
                        chk("busy_cycles", busy_cnt, e.busy_cycles);
                        chk("ready_low_cycles", rdy_lo_cnt, e.busy_cycles);
                    end
                    busy_cnt   = 0;
                    rdy_lo_cnt = 0;
                end else begin
                    if (busy) busy_cnt++;
                    if (!cmd_ready) rdy_lo_cnt++;
                end
            end
        end
    end

    initial begin
        //             mode     N      pi     slr   sll   z      so    busy
        vecs[0]  = '{M_LOAD,  4'd0,  8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 0};
        vecs[1]  = '{M_SHR,   4'd3,  8'h00, 1'b1, 1'b0, 8'hF4, 1'b1, 2};
        vecs[2]  = '{M_LOAD,  4'd0,  8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 0};
        vecs[3]  = '{M_ROL,   4'd8,  8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 7};
        vecs[4]  = '{M_SHR,   4'd0,  8'h00, 1'b1, 1'b1, 8'hA5, 1'b1, 0};
        vecs[5]  = '{M_NOP,   4'd5,  8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 0};
        vecs[6]  = '{M_LOAD,  4'd0,  8'h96, 1'b0, 1'b0, 8'h96, 1'b1, 0};
        vecs[7]  = '{M_ASR,   4'd2,  8'h00, 1'b0, 1'b0, 8'hE5, 1'b1, 1};
        vecs[8]  = '{M_CLEAR, 4'd0,  8'h77, 1'b1, 1'b1, 8'h00, 1'b0, 0};
        vecs[9]  = '{M_LOAD,  4'd0,  8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 0};
        vecs[10] = '{M_SHL,   4'd1,  8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 0};
        vecs[11] = '{M_LOAD,  4'd0,  8'h81, 1'b0, 1'b0, 8'h81, 1'b1, 0};
        vecs[12] = '{M_ROR,   4'd3,  8'h00, 1'b0, 1'b0, 8'h30, 1'b0, 2};
        vecs[13] = '{M_SHL,   4'd2,  8'h00, 1'b0, 1'b1, 8'hC3, 1'b0, 1};
        vecs[14] = '{M_ASR,   4'd15, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 14};
        vecs[15] = '{M_SHR,   4'd9,  8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8};
        vecs[16] = '{M_LOAD,  4'd0,  8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 0};

        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode = M_NOP;
        cmd_count = '0;
        pi = '0;
        sl_r = 1'b0;
        sl_l = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_z", {24'd0, z}, 32'd0);
        chk("reset_so", {31'd0, so}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b1;
        mon_on = 1;
        @(negedge clk);

        // Table: each vector runs on the register state left by the previous one.
        for (int i = 0; i < 17; i++) begin
            start_cmd(vecs[i].mode, vecs[i].count, vecs[i].pi, vecs[i].sl_r, vecs[i].sl_l, 1,
                      vecs[i].exp_z, vecs[i].exp_so, vecs[i].exp_busy);
            wait_idle();
        end

        // SHL 12 with a LOAD held on cmd_valid throughout the busy window; it must wait.
        start_cmd(M_SHL, 4'd12, 8'h00, 1'b0, 1'b0, 1, 8'h00, 1'b0, 11);
        start_cmd(M_LOAD, 4'd0, 8'h55, 1'b0, 1'b0, 1, 8'h55, 1'b0, 0);
        wait_idle();

        // ROR 10 aborted by reset part-way through: no done, outputs cleared at once.
        start_cmd(M_ROR, 4'd10, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_z", {24'd0, z}, 32'd0);
        chk("abort_so", {31'd0, so}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_abort_ready", {31'd0, cmd_ready}, 32'd1);
        start_cmd(M_LOAD, 4'd0, 8'h3C, 1'b0, 1'b0, 1, 8'h3C, 1'b0, 0);
        wait_idle();

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/usr_multi_shift.md
# usr_multi_shift

Parametrised successor to the 4-bit universal shift register: a WIDTH-bit register that accepts one command at a time over a valid/ready handshake and executes it over one or more clock cycles. Shift and rotate commands carry a step count and run one bit per cycle under a small state machine, with busy status, a done pulse and a serial-out bit. It sits between a control sequencer and any datapath needing serialisation, bit alignment or multi-bit rotation.

## Interface
- WIDTH, 8, register width; legal range ≥ 2
- CW, 4, width of the command step-count field

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high in IDLE)
- cmd_mode  in  3  operation code (see Operation)
- cmd_count  in  CW  number of single-bit steps for shift/rotate modes
- pi  in  WIDTH  parallel-load data, sampled at accept
- sl_r  in  1  serial input entering MSB on SHR, sampled each step
- sl_l  in  1  serial input entering LSB on SHL, sampled each step
- z  out  WIDTH  register contents
- so  out  1  bit most recently shifted/rotated out
- busy  out  1  multi-cycle command in progress
- done  out  1  one-cycle pulse: command complete, z final

## Operation
- Modes: 000 NOP; 001 SHR logical, sl_r into MSB; 010 SHL, sl_l into LSB; 011 LOAD z←pi; 100 ROR; 101 ROL; 110 ASR, MSB replicated; 111 CLEAR z←0, so←0.
- Accept = cmd_valid && cmd_ready at a rising edge. mode/count latched; pi, sl_r, sl_l need not be held after accept except sl_r/sl_l, which are sampled live at every step edge.
- FSM states IDLE, RUN.
  - IDLE: cmd_ready=1, busy=0. On accept of shift/rotate mode with N≥1: first step at the accept edge, remaining←N−1; go RUN if remaining>0 else stay IDLE.
  - On accept of LOAD/CLEAR: update at accept edge, stay IDLE. NOP, or shift/rotate with N=0: z and so unchanged, stay IDLE.
  - RUN: cmd_ready=0, busy=1; one step per edge, remaining decrements; leave to IDLE at the edge performing the final step.
- done=1 for exactly one cycle after the edge that completes any command (including NOP and N=0).
- so updated on every step: LSB leaving for SHR/ROR/ASR, MSB leaving for SHL/ROL. LOAD and NOP leave so unchanged.
- N may exceed WIDTH: SHR/SHL keep filling from serial input, ROR/ROL wrap, ASR saturates to all-sign.
- cmd_valid while busy: ignored, no queuing; requester holds command until accepted.
- Back-to-back: the cycle carrying done is IDLE, so a new command is accepted on the following edge.

## Timing
- Reset (rst low, asynchronous): z=0, so=0, busy=0, done=0, state IDLE (cmd_ready=1 combinationally from state).
- Reset mid-RUN: command aborted immediately, all outputs to reset values, no done pulse.
- Shift/rotate N≥1: z final after accept edge + (N−1) edges; done high during the cycle following that edge; busy high N−1 cycles; cmd_ready low N−1 cycles.
- LOAD/CLEAR/NOP/N=0: done in the cycle after the accept edge; busy never asserted.
- Throughput: one step per clock; max one command per cycle for single-cycle commands.

## Test plan
- Reset then LOAD pi=8'hA5 → z=8'hA5 after accept edge, done one cycle, busy never high, cmd_ready stays 1.
- From z=8'hA5, SHR N=3, sl_r=1 → z=8'hF4, so=1, busy high 2 cycles, done in cycle after third step.
- From z=8'hA5, ROL N=8 → z=8'hA5, so=1; then SHR N=0 → z unchanged, done next cycle.
- Load 8'h96, ASR N=2 → z=8'hE5, so=1; immediate back-to-back CLEAR accepted in done cycle's next edge → z=0, so=0.
- Load 8'hFF, SHL N=12, sl_l=0 → z=8'h00, so=0, cmd_ready low 11 cycles, cmd_valid asserted during busy ignored.
- ROR N=10 started, rst driven low at step 4 → z=0, busy=0, no done; after release cmd_ready=1 and LOAD accepted normally.
